// File: rtl/mem_pkg.sv
// Shared definitions for the unified 1024x16 memory and its copy engine.
// Address/data widths, copy FSM states and copy direction.
package mem_pkg;

   localparam int ADDR_W    = 10;
   localparam int DATA_W    = 16;
   localparam int MEM_DEPTH = 1 << ADDR_W;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      COPY = 2'd1,
      DONE = 2'd2
   } copy_state_t;

   typedef enum logic {
      DIR_ASC  = 1'b0,
      DIR_DESC = 1'b1
   } copy_dir_t;

endpackage

// File: rtl/mem_copy_addr_gen.sv
// Copy address generator: holds the captured bases, running offset, remaining
// word count and direction; produces the current read/write addresses.
module mem_copy_addr_gen #(
   parameter int ADDR_W = mem_pkg::ADDR_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic              step,
   input  logic [ADDR_W-1:0] src,
   input  logic [ADDR_W-1:0] dst,
   input  logic [ADDR_W:0]   len,
   output logic [ADDR_W-1:0] rd_addr,
   output logic [ADDR_W-1:0] wr_addr,
   output logic              last
);
   import mem_pkg::*;

   logic [ADDR_W-1:0] src_q;
   logic [ADDR_W-1:0] dst_q;
   logic [ADDR_W-1:0] offset_q;
   logic [ADDR_W:0]   remain_q;
   copy_dir_t         dir_q;
   copy_dir_t         dir_d;
   logic [ADDR_W-1:0] len_m1;

   // Copying downwards when the destination sits above the source keeps an
   // overlapping region from being overwritten before it is read.
   assign dir_d  = (dst > src) ? DIR_DESC : DIR_ASC;
   assign len_m1 = ADDR_W'(len - 1'b1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         src_q    <= '0;
         dst_q    <= '0;
         offset_q <= '0;
         remain_q <= '0;
         dir_q    <= DIR_ASC;
      end else if (load) begin
         src_q    <= src;
         dst_q    <= dst;
         remain_q <= len;
         dir_q    <= dir_d;
         offset_q <= (dir_d == DIR_DESC) ? len_m1 : '0;
      end else if (step && (remain_q != '0)) begin
         remain_q <= remain_q - 1'b1;
         offset_q <= (dir_q == DIR_DESC) ? offset_q - 1'b1 : offset_q + 1'b1;
      end
   end

   // Address sums wrap naturally at the memory depth.
   assign rd_addr = src_q + offset_q;
   assign wr_addr = dst_q + offset_q;
   assign last    = (remain_q == {{ADDR_W{1'b0}}, 1'b1});

endmodule

// File: rtl/mem_copy_ctrl.sv
// Block-copy engine and port arbiter for the shared write port and read port 2.
// CPU accesses always win; the copy advances only in cycles the CPU leaves free.
//
//   state | meaning
//   IDLE  | waiting for start; CPU traffic passes straight through
//   COPY  | one word moved per cycle with no CPU access on either port
//   DONE  | one-cycle completion pulse, then back to IDLE
module mem_copy_ctrl #(
   parameter int ADDR_W = mem_pkg::ADDR_W,
   parameter int DATA_W = mem_pkg::DATA_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_waddr,
   input  logic [DATA_W-1:0] cpu_wdata,
   input  logic              cpu_re2,
   input  logic [ADDR_W-1:0] cpu_raddr2,
   input  logic              start,
   input  logic [ADDR_W-1:0] src,
   input  logic [ADDR_W-1:0] dst,
   input  logic [ADDR_W:0]   len,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_waddr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [ADDR_W-1:0] mem_raddr2,
   input  logic [DATA_W-1:0] mem_rdata2,
   output logic              busy,
   output logic              done
);
   import mem_pkg::*;

   copy_state_t       state_q;
   copy_state_t       state_d;
   logic              busy_q;
   logic              done_q;
   logic              load;
   logic              grant;
   logic              last;
   logic [ADDR_W-1:0] rd_addr;
   logic [ADDR_W-1:0] wr_addr;

   assign grant = (state_q == COPY) && !cpu_we && !cpu_re2;

   mem_copy_addr_gen #(
      .ADDR_W (ADDR_W)
   ) u_addr_gen (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (load),
      .step    (grant),
      .src     (src),
      .dst     (dst),
      .len     (len),
      .rd_addr (rd_addr),
      .wr_addr (wr_addr),
      .last    (last)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         busy_q  <= (state_d == COPY);
         done_q  <= (state_d == DONE);
      end
   end

   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               if (len != '0) begin
                  load    = 1'b1;
                  state_d = COPY;
               end else begin
                  state_d = DONE;
               end
            end
         end
         COPY: begin
            if (grant && last) state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs are held at zero while reset is asserted, so no stray write can
   // reach the memory during an abandoned copy.
   always_comb begin
      mem_we     = 1'b0;
      mem_waddr  = '0;
      mem_wdata  = '0;
      mem_raddr2 = '0;
      if (rst_n) begin
         if (grant) begin
            mem_we     = 1'b1;
            mem_waddr  = wr_addr;
            mem_wdata  = mem_rdata2;
            mem_raddr2 = rd_addr;
         end else begin
            mem_we     = cpu_we;
            mem_waddr  = cpu_waddr;
            mem_wdata  = cpu_wdata;
            mem_raddr2 = cpu_raddr2;
         end
      end
   end

   assign busy = busy_q;
   assign done = done_q;

endmodule

// File: tb/tb_mem_copy_ctrl.sv
// Self-checking bench for mem_copy_ctrl: behavioural 1024x16 memory, a
// sequential-copy reference model, table-driven and randomized copies.
module tb_mem_copy_ctrl;

   localparam int AW = 10;
   localparam int DW = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          cpu_we = 1'b0;
   logic [AW-1:0] cpu_waddr = '0;
   logic [DW-1:0] cpu_wdata = '0;
   logic          cpu_re2 = 1'b0;
   logic [AW-1:0] cpu_raddr2 = '0;
   logic          start = 1'b0;
   logic [AW-1:0] src = '0;
   logic [AW-1:0] dst = '0;
   logic [AW:0]   len = '0;
   logic          mem_we;
   logic [AW-1:0] mem_waddr;
   logic [DW-1:0] mem_wdata;
   logic [AW-1:0] mem_raddr2;
   logic [DW-1:0] mem_rdata2;
   logic          busy;
   logic          done;

   int checks = 0;
   int errors = 0;

   logic [DW-1:0] mem     [0:1023];
   logic [DW-1:0] ref_mem [0:1023];
   logic          sync_req = 1'b0;

   typedef struct {
      logic [AW-1:0] src;
      logic [AW-1:0] dst;
      logic [AW:0]   len;
      logic [31:0]   we_mask;
      logic [31:0]   re_mask;
      bit            beef;
      int            exp_done;
   } case_t;

   case_t tbl [8];

   always #5 clk = ~clk;

   mem_copy_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cpu_we     (cpu_we),
      .cpu_waddr  (cpu_waddr),
      .cpu_wdata  (cpu_wdata),
      .cpu_re2    (cpu_re2),
      .cpu_raddr2 (cpu_raddr2),
      .start      (start),
      .src        (src),
      .dst        (dst),
      .len        (len),
      .mem_we     (mem_we),
      .mem_waddr  (mem_waddr),
      .mem_wdata  (mem_wdata),
      .mem_raddr2 (mem_raddr2),
      .mem_rdata2 (mem_rdata2),
      .busy       (busy),
      .done       (done)
   );

   assign mem_rdata2 = mem[mem_raddr2];

   always @(posedge clk) begin
      if (sync_req) begin
         for (int i = 0; i < 1024; i++) mem[i] <= ref_mem[i];
      end else if (mem_we) begin
         mem[mem_waddr] <= mem_wdata;
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic sync_mem();
      @(posedge clk); #1;
      sync_req = 1'b1;
      @(posedge clk); #1;
      sync_req = 1'b0;
   endtask

   task automatic check_mem_image(input string name);
      int n;
      n = 0;
      for (int i = 0; i < 1024; i++) if (mem[i] !== ref_mem[i]) n++;
      check(name, 64'(n), 64'd0);
   endtask

   task automatic run_copy(input case_t c, input string tag);
      logic [AW-1:0] qs[$];
      logic [AW-1:0] qd[$];
      logic [AW-1:0] s, d;
      logic [38:0]   act_v, exp_v;
      logic          cw, cr, pend;
      int            off, done_rel;
      bit            desc;

      @(posedge clk); #1;
      start = 1'b1; src = c.src; dst = c.dst; len = c.len;
      cpu_we = 1'b0; cpu_re2 = 1'b0;
      desc = (c.dst > c.src);
      for (int k = 0; k < int'(c.len); k++) begin
         off = desc ? int'(c.len) - 1 - k : k;
         qs.push_back(AW'(int'(c.src) + off));
         qd.push_back(AW'(int'(c.dst) + off));
      end
      @(negedge clk);
      check({tag, " idle"}, {62'd0, busy, done}, 64'd0);

      done_rel = -1;
      for (int rel = 1; rel <= int'(c.len) + 40 && done_rel < 0; rel++) begin
         @(posedge clk); #1;
         start      = 1'($urandom_range(0, 1));
         cw         = (rel < 32) ? c.we_mask[rel] : 1'b0;
         cr         = (rel < 32) ? c.re_mask[rel] : 1'b0;
         cpu_we     = cw;
         cpu_re2    = cr;
         cpu_waddr  = c.beef ? AW'(5) : AW'($urandom);
         cpu_wdata  = c.beef ? 16'hBEEF : DW'($urandom);
         cpu_raddr2 = AW'($urandom);
         @(negedge clk);
         pend = (qs.size() != 0);
         if (pend && !cw && !cr) begin
            s = qs.pop_front();
            d = qd.pop_front();
            exp_v = {1'b1, d, ref_mem[s], s, 1'b1, 1'b0};
            ref_mem[d] = ref_mem[s];
         end else begin
            exp_v = {cw, cpu_waddr, cpu_wdata, cpu_raddr2, pend, !pend};
            if (!pend) done_rel = rel;
         end
         if (cw) ref_mem[cpu_waddr] = cpu_wdata;
         act_v = {mem_we, mem_waddr, mem_wdata, mem_raddr2, busy, done};
         check($sformatf("%s cycle T+%0d", tag, rel), 64'(act_v), 64'(exp_v));
      end

      @(posedge clk); #1;
      start = 1'b0; cpu_we = 1'b0; cpu_re2 = 1'b0;
      @(negedge clk);
      check({tag, " done_seen"}, 64'(done_rel >= 0), 64'd1);
      check({tag, " back_idle"}, {61'd0, busy, done, mem_we}, 64'd0);
      if (c.exp_done >= 0) check({tag, " done_cycle"}, 64'(done_rel), 64'(c.exp_done));
      check_mem_image({tag, " mem_image"});
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      case_t rc;
      int    bad;

      tbl[0] = '{10'd401, 10'd100,  11'd4,    32'h0, 32'h0, 1'b0, 5};
      tbl[1] = '{10'd10,  10'd12,   11'd4,    32'h0, 32'h0, 1'b0, 5};
      tbl[2] = '{10'd0,   10'd1022, 11'd3,    32'h0, 32'h0, 1'b0, 4};
      tbl[3] = '{10'd50,  10'd60,   11'd0,    32'h0, 32'h0, 1'b0, 1};
      tbl[4] = '{10'd200, 10'd300,  11'd3,    32'h4, 32'h8, 1'b1, 6};
      tbl[5] = '{10'd500, 10'd200,  11'd1,    32'h0, 32'h0, 1'b0, 2};
      tbl[6] = '{10'd7,   10'd7,    11'd2,    32'h0, 32'h0, 1'b0, 3};
      tbl[7] = '{10'd0,   10'd1,    11'd1024, 32'h0, 32'h0, 1'b0, 1025};

      // Reset state with CPU inputs active: every output must be zero.
      cpu_we = 1'b1; cpu_waddr = '1; cpu_wdata = '1; cpu_re2 = 1'b1; cpu_raddr2 = '1;
      #3;
      check("reset outputs", {25'd0, mem_we, mem_waddr, mem_wdata, mem_raddr2, busy, done}, 64'd0);
      cpu_we = 1'b0; cpu_re2 = 1'b0;
      for (int i = 0; i < 1024; i++) ref_mem[i] = DW'($urandom);
      sync_mem();
      @(posedge clk); #1;
      rst_n = 1'b1;

      for (int i = 0; i < 8; i++) begin
         if (i == 1) begin
            ref_mem[10] = 16'hAAAA; ref_mem[11] = 16'hBBBB;
            ref_mem[12] = 16'hCCCC; ref_mem[13] = 16'hDDDD;
            sync_mem();
         end
         run_copy(tbl[i], $sformatf("tbl%0d", i));
         if (i == 1)
            check("overlap result", {mem[12], mem[13], mem[14], mem[15]}, 64'hAAAA_BBBB_CCCC_DDDD);
         if (i == 4)
            check("cpu store", 64'(mem[5]), 64'hBEEF);
      end

      // Reset asserted mid-copy after two words have been written.
      @(posedge clk); #1;
      start = 1'b1; src = 10'd600; dst = 10'd300; len = 11'd8;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk);
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      check("mid reset outputs", {61'd0, mem_we, busy, done}, 64'd0);
      ref_mem[300] = ref_mem[600];
      ref_mem[301] = ref_mem[601];
      @(posedge clk);
      @(posedge clk); #1;
      rst_n = 1'b1;
      bad = 0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if ({mem_we, busy, done} !== 3'b000) bad++;
      end
      check("post reset quiet", 64'(bad), 64'd0);
      check_mem_image("mid reset mem_image");
      rc = '{10'd20, 10'd40, 11'd5, 32'h0, 32'h0, 1'b0, 6};
      run_copy(rc, "after_reset");

      for (int r = 0; r < 10; r++) begin
         rc.src      = AW'($urandom);
         rc.dst      = (r % 2 == 0) ? AW'($urandom) : AW'(int'(rc.src) + $urandom_range(0, 8) - 4);
         rc.len      = (AW + 1)'($urandom_range(0, 40));
         rc.we_mask  = $urandom & $urandom;
         rc.re_mask  = $urandom & $urandom;
         rc.beef     = 1'b0;
         rc.exp_done = -1;
         run_copy(rc, $sformatf("rand%0d", r));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_copy_ctrl.md
# mem_copy_ctrl

Copy engine and port arbiter for the unified 1024×16 instruction/data memory. It owns write port and data read port 2 of the memory and shares them between the CPU (load/store traffic) and an internal block-copy engine. The copy engine moves `len` words from `src` to `dst` one word per granted cycle, using the memory's combinational read path. CPU accesses always win; the copy stalls on any CPU access to either shared port.

## Interface
- `ADDR_W`, 10: memory address width; depth 2^ADDR_W.
- `DATA_W`, 16: word width.

- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `cpu_we`  in  1  CPU store request.
- `cpu_waddr`  in  ADDR_W  CPU store address.
- `cpu_wdata`  in  DATA_W  CPU store data.
- `cpu_re2`  in  1  CPU wants read port 2 this cycle.
- `cpu_raddr2`  in  ADDR_W  CPU read-port-2 address.
- `start`  in  1  copy request; sampled only in IDLE.
- `src`, `dst`  in  ADDR_W each  copy source and destination base; captured on accepted `start`.
- `len`  in  ADDR_W+1  word count, 0..1024; captured on accepted `start`.
- `mem_we`  out  1  memory write enable.
- `mem_waddr`  out  ADDR_W  memory write address.
- `mem_wdata`  out  DATA_W  memory write data.
- `mem_raddr2`  out  ADDR_W  memory data read address 2.
- `mem_rdata2`  in  DATA_W  memory data_out2 (combinational read).
- `busy`  out  1  high in COPY.
- `done`  out  1  one-cycle pulse on copy completion.

## Operation
- FSM states: IDLE, COPY, DONE.
- IDLE: `start`=1 with `len`≠0 → capture `src`/`dst`/`len`, set direction, go to COPY. `start`=1 with `len`=0 → DONE. `start` in COPY or DONE is ignored and not queued.
- Direction: descending when `dst` > `src` (unsigned), otherwise ascending. Descending: offset starts at `len`-1 and decrements. Ascending: offset starts at 0 and increments.
- Copy address: `src`+offset and `dst`+offset, both modulo 2^ADDR_W. Wrap past 1023 to 0 is legal. Correctness of an overlapping copy that wraps is not guaranteed; only the write order above is guaranteed.
- Grant: the copy engine is granted in a cycle iff state=COPY, `cpu_we`=0 and `cpu_re2`=0.
- Granted cycle:
  - `mem_raddr2`=`src`+offset, `mem_we`=1, `mem_waddr`=`dst`+offset, `mem_wdata`=`mem_rdata2`.
  - Remaining count decrements and offset steps.
  - The last word takes the FSM to DONE.
- Non-granted cycle: the CPU signals pass straight through (`mem_we`=`cpu_we`, `mem_waddr`/`mem_wdata`=CPU values, `mem_raddr2`=`cpu_raddr2`). The copy state holds.
- DONE: `done`=1 for exactly one cycle, then IDLE.
- Reset (async, any state, including mid-copy): FSM to IDLE, counters cleared, `busy`=0, `done`=0. `mem_we` is forced to 0 while `rst_n`=0. A partially completed copy is abandoned, and already-written words stay written.

## Timing
- Reset values: `busy` 0, `done` 0, `mem_we` 0, `mem_waddr` 0, `mem_wdata` 0, `mem_raddr2` 0 (CPU pass-through resumes on the first cycle after reset release).
- Write and port-mux outputs are combinational from registered state and CPU inputs. `busy` and `done` are registered.
- `start` accepted at edge T → first possible copy write in cycle T+1.
- With no CPU contention, `len`=N → writes in cycles T+1..T+N, `done` in cycle T+N+1, IDLE at T+N+2. Each CPU-access cycle during COPY adds exactly one cycle.
- `len`=0 → `done` in cycle T+1, no write.
- The memory writes at the edge closing the granted cycle. The read in the same cycle sees the pre-write contents.

## Structure
- Shared package `mem_pkg`: `ADDR_W`, `DATA_W`, `MEM_DEPTH`=1024, the copy state enum (IDLE/COPY/DONE), and the direction type.
- One sub-module, `mem_copy_addr_gen`:
  - Holds base addresses, offset, remaining count and direction.
  - Inputs: `load`, `step`.
  - Outputs: `rd_addr`, `wr_addr`, `last`.
- The FSM and port mux stay in the top.

## Test plan
- Plain copy: `src`=401, `dst`=100, `len`=4, no CPU traffic → writes to 100..103 in cycles T+1..T+4 with data from 401..404, `done` at T+5.
- Overlap descending: mem[10..13]=A,B,C,D; `src`=10, `dst`=12, `len`=4 → writes in order 15,14,13,12; final mem[12..15]=A,B,C,D.
- Contention:
  - Stimulus: `cpu_we`=1 (addr 5, data 0xBEEF) in T+2 and `cpu_re2`=1 in T+3 during a `len`=3 copy.
  - Required: mem[5]=0xBEEF; copy writes in T+1, T+4, T+5; `done` at T+6.
- Wrap and zero length:
  - `dst`=1022, `src`=0, `len`=3 → writes to 1022,1023,0.
  - `len`=0 → `done` at T+1 and `mem_we` never asserted by the copy.
- Reset mid-copy:
  - Stimulus: `rst_n` low asynchronously after two words of a `len`=8 copy.
  - Required: `mem_we`=0 and `busy`=0 immediately, no further copy writes, no `done`.
  - After release, `start` is accepted normally.
